// File: rtl/key_repeater.sv
// Purpose: turns a debounced key level into one-clock press/release/auto-repeat strobes.
// Latency: every output is registered and appears one clock after the edge that decides it.
// Backpressure: none; strobes are fire-and-forget, and repeat timing advances only on i_tick.
module key_repeater #(
  parameter int initialDelay = 500,  // ticks from press to first repeat (1..65535)
  parameter int repeatPeriod = 100   // ticks between later repeats (1..65535)
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_in,
  output logic o_pressed,
  output logic o_released,
  output logic o_repeat,
  output logic o_event,
  output logic o_held
);

  // Out-of-range delays would silently wrap the 16-bit compare, so stop elaboration.
  if (initialDelay < 1 || initialDelay > 65535) begin : g_bad_delay
    $error("key_repeater: initialDelay %0d outside 1..65535", initialDelay);
  end
  if (repeatPeriod < 1 || repeatPeriod > 65535) begin : g_bad_period
    $error("key_repeater: repeatPeriod %0d outside 1..65535", repeatPeriod);
  end

  // Terminal counts, truncated to the counter width.
  localparam logic [15:0] DLY_LAST = 16'(initialDelay - 1);
  localparam logic [15:0] PER_LAST = 16'(repeatPeriod - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_pressed;
  logic        r_released;
  logic        r_repeat;
  logic        r_event;
  logic        r_held;

  logic        w_dly_hit;
  logic        w_per_hit;
  logic [15:0] w_cnt_inc;

  // Expiry compares; only consulted in the state that owns them.
  assign w_dly_hit = (r_cnt == DLY_LAST);
  assign w_per_hit = (r_cnt == PER_LAST);
  assign w_cnt_inc = r_cnt + 16'd1;

  // Key FSM with the tick counter; strobes default low so each lasts one clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_repeat   <= 1'b0;
      r_event    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_repeat   <= 1'b0;
      r_event    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A tick coinciding with the press is dropped: the count starts fresh.
          if (i_in) begin
            r_pressed <= 1'b1;
            r_event   <= 1'b1;
            r_held    <= 1'b1;
            r_cnt     <= 16'd0;
            r_state   <= S_DELAY;
          end
        end
        S_DELAY: begin
          // Release wins over a same-cycle expiry, so no repeat can follow a release.
          if (!i_in) begin
            r_released <= 1'b1;
            r_held     <= 1'b0;
            r_cnt      <= 16'd0;
            r_state    <= S_IDLE;
          end else if (i_tick) begin
            if (w_dly_hit) begin
              r_repeat <= 1'b1;
              r_event  <= 1'b1;
              r_cnt    <= 16'd0;
              r_state  <= S_REPEAT;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_REPEAT: begin
          if (!i_in) begin
            r_released <= 1'b1;
            r_held     <= 1'b0;
            r_cnt      <= 16'd0;
            r_state    <= S_IDLE;
          end else if (i_tick) begin
            if (w_per_hit) begin
              r_repeat <= 1'b1;
              r_event  <= 1'b1;
              r_cnt    <= 16'd0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to idle without emitting anything.
          r_held  <= 1'b0;
          r_cnt   <= 16'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_repeat   = r_repeat;
  assign o_event    = r_event;
  assign o_held     = r_held;

endmodule

// File: tb/tb_key_repeater.sv
// Bench for key_repeater: four parameterisations share one stimulus stream and are
// each checked every cycle against a tick-counting reference model.
module tb_key_repeater;

  localparam int NI = 4;
  localparam int DLY [NI] = '{3, 2, 1, 65535};
  localparam int PER [NI] = '{2, 3, 1, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_r = 1'b0;
  logic tick_r = 1'b0;

  logic [NI-1:0] o_p, o_r, o_rep, o_ev, o_h;
  logic [NI-1:0] e_p, e_r, e_rep, e_ev, e_h;

  bit m_held [NI];
  int m_ticks [NI];
  int cnt_rep [NI];
  int cnt_ev [NI];
  int cnt_rel [NI];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  key_repeater #(.initialDelay(3), .repeatPeriod(2)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_r), .i_in(in_r),
    .o_pressed(o_p[0]), .o_released(o_r[0]), .o_repeat(o_rep[0]),
    .o_event(o_ev[0]), .o_held(o_h[0]));
  key_repeater #(.initialDelay(2), .repeatPeriod(3)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_r), .i_in(in_r),
    .o_pressed(o_p[1]), .o_released(o_r[1]), .o_repeat(o_rep[1]),
    .o_event(o_ev[1]), .o_held(o_h[1]));
  key_repeater #(.initialDelay(1), .repeatPeriod(1)) u_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_r), .i_in(in_r),
    .o_pressed(o_p[2]), .o_released(o_r[2]), .o_repeat(o_rep[2]),
    .o_event(o_ev[2]), .o_held(o_h[2]));
  key_repeater #(.initialDelay(65535), .repeatPeriod(3)) u_d (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_r), .i_in(in_r),
    .o_pressed(o_p[3]), .o_released(o_r[3]), .o_repeat(o_rep[3]),
    .o_event(o_ev[3]), .o_held(o_h[3]));

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a held key repeats on tick number D after the press, then every P ticks.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      e_p[i] = 1'b0; e_r[i] = 1'b0; e_rep[i] = 1'b0;
      if (!m_held[i]) begin
        if (in_r) begin
          e_p[i] = 1'b1;
          m_held[i] = 1'b1;
          m_ticks[i] = 0;
        end
      end else if (!in_r) begin
        e_r[i] = 1'b1;
        m_held[i] = 1'b0;
      end else if (tick_r) begin
        m_ticks[i]++;
        if (m_ticks[i] >= DLY[i] && ((m_ticks[i] - DLY[i]) % PER[i]) == 0)
          e_rep[i] = 1'b1;
      end
      e_ev[i] = e_p[i] | e_rep[i];
      e_h[i]  = m_held[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_held[i] = 1'b0;
      m_ticks[i] = 0;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NI; i++) begin
      cnt_rep[i] = 0; cnt_ev[i] = 0; cnt_rel[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk("pressed", i, o_p[i], e_p[i]);
      chk("released", i, o_r[i], e_r[i]);
      chk("repeat", i, o_rep[i], e_rep[i]);
      chk("event", i, o_ev[i], e_ev[i]);
      chk("held", i, o_h[i], e_h[i]);
      chk("onehot", i, ($countones({o_p[i], o_r[i], o_rep[i]}) <= 1), 1'b1);
      if (o_rep[i] === 1'b1) cnt_rep[i]++;
      if (o_ev[i] === 1'b1) cnt_ev[i]++;
      if (o_r[i] === 1'b1) cnt_rel[i]++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++)
      chk(tag, i, |{o_p[i], o_r[i], o_rep[i], o_ev[i], o_h[i]}, 1'b0);
  endtask

  // One clock: inputs already stable, model consumes the same sample, outputs read 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int e_cyc;
    int r_cyc;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    run(2);

    // Basic press/release with tick tied high.
    clear_counts();
    tick_r = 1'b1;
    in_r = 1'b1;
    run(10);
    in_r = 1'b0;
    run(3);
    chk_int("basic_repeat_count_a", cnt_rep[0], 4);
    chk_int("basic_release_count_a", cnt_rel[0], 1);

    // Sparse tick, one tick every 4th cycle, key held.
    clear_counts();
    in_r = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick_r = ((cyc % 4) == 0);
      step();
    end
    in_r = 1'b0;
    tick_r = 1'b1;
    run(2);
    chk_int("sparse_repeat_count_b", cnt_rep[1], 3);

    // Release on the edge where the delay would expire for instance A.
    clear_counts();
    tick_r = 1'b1;
    in_r = 1'b1;
    run(3);
    in_r = 1'b0;
    run(2);
    chk_int("expiry_release_no_repeat_a", cnt_rep[0], 0);
    chk("expiry_idle", 0, o_h[0], 1'b0);

    // Short tap.
    clear_counts();
    in_r = 1'b1;
    run(1);
    in_r = 1'b0;
    run(2);
    chk_int("tap_event_count_a", cnt_ev[0], 1);
    chk_int("tap_repeat_count_c", cnt_rep[2], 0);

    // Re-press on the edge right after a release edge.
    in_r = 1'b1;
    run(4);
    in_r = 1'b0;
    run(1);
    in_r = 1'b1;
    run(2);
    in_r = 1'b0;
    run(2);

    // Randomized levels and ticks.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) in_r = ~in_r;
      tick_r = ($urandom_range(0, 2) != 0);
      step();
    end

    // Asynchronous reset in the middle of a repeat stream.
    tick_r = 1'b1;
    in_r = 1'b0;
    run(1);
    in_r = 1'b1;
    run(20);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    run(4);
    in_r = 1'b0;
    run(2);

    // Long delay: first repeat of instance D exactly 65535 edges after the press edge.
    clear_counts();
    tick_r = 1'b1;
    in_r = 1'b1;
    step();
    e_cyc = cyc;
    chk("long_pressed", 3, o_p[3], 1'b1);
    r_cyc = -1;
    for (int k = 0; k < 65600 && r_cyc < 0; k++) begin
      step();
      if (o_rep[3] === 1'b1) r_cyc = cyc;
    end
    if (r_cyc < 0) chk_int("long_repeat_timeout", 0, 1);
    else chk_int("long_first_repeat_delay", r_cyc - e_cyc, 65535);
    run(4);
    in_r = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
